control_unit: RTL

// Multicycle Moore FSM driving every datapath control wire of the CPU top (PC/A/B/ALUOut/EPC loads,

---
 rtl/control_unit.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// Multicycle Moore control unit for the CPU datapath.
// Optional feature: define EXCEPTION_EN to trap unknown opcode/funct and
// signed overflow (EPC save + vector fetch from byte 253/254). Without it,
// unknown instructions behave as NOPs and overflow is ignored.
// dbg_state exposes the current FSM state for checkers and benches.
module control_unit #(
  parameter int MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       overflow,
  output logic       pc_write,
  output logic       mem_wr,
  output logic       ir_load,
  output logic       ab_load,
  output logic       aluout_load,
  output logic       epc_load,
  output logic       reg_write,
  output logic       sel_alusrca,
  output logic [1:0] sel_alusrcb,
  output logic [2:0] alu_op,
  output logic [2:0] sel_mux_iord,
  output logic [2:0] sel_pc_source,
  output logic [1:0] sel_reg_dst,
  output logic [2:0] sel_mem_to_reg,
  output logic       sel_shift_src,
  output logic [1:0] sel_shift_amt,
  output logic [2:0] sel_shift_reg,
  output logic [4:0] dbg_state
);

`ifdef EXCEPTION_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  localparam logic [1:0] WAIT_N = 2'(MEM_WAIT);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_JR = 6'h08,
                         FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_SLT = 6'h2A;

  typedef enum logic [4:0] {
    S_RESET = 5'd0, S_FETCH = 5'd1, S_FETCH_WAIT = 5'd2, S_FETCH_END = 5'd3,
    S_DECODE = 5'd4, S_EXEC_R = 5'd5, S_WB_R = 5'd6, S_JR = 5'd7,
    S_SH_LOAD = 5'd8, S_SH_OP = 5'd9, S_EXEC_I = 5'd10, S_WB_I = 5'd11,
    S_MEM_ADDR = 5'd12, S_MEM_RD = 5'd13, S_LW_WAIT = 5'd14, S_WB_LW = 5'd15,
    S_MEM_WR = 5'd16, S_BRANCH = 5'd17, S_JUMP = 5'd18, S_JAL = 5'd19,
    S_EXC_OPC = 5'd20, S_EXC_OVF = 5'd21, S_EXC_ADDR = 5'd22, S_EXC_WAIT = 5'd23,
    S_EXC_DATA = 5'd24, S_EXC_PC = 5'd25
  } state_t;

  typedef struct packed {
    logic       pc_write, mem_wr, ir_load, ab_load, aluout_load, epc_load, reg_write, alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alu_op, iord, pc_source;
    logic [1:0] reg_dst;
    logic [2:0] mem_to_reg;
    logic       shift_src;
    logic [1:0] shift_amt;
    logic [2:0] shift_reg;
  } ctrl_t;

  state_t     state, nxt;
  ctrl_t      ctrl;
  logic [1:0] wait_cnt;
  logic       wait_done, branch_taken;

  function automatic logic is_wait(input state_t s);
    return (s == S_FETCH_WAIT) || (s == S_LW_WAIT) || (s == S_EXC_WAIT);
  endfunction

  // Control word for a state; funct is stable from DECODE until the next fetch,
  // and the exception vector select is carried over from the entry state.
  function automatic ctrl_t ctrl_of(input state_t s, input logic [5:0] fn, input logic [2:0] iord_hold);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH, S_FETCH_WAIT: begin c.alusrcb = 2'b01; c.alu_op = 3'b001; end
      S_FETCH_END: begin
        c.alusrcb = 2'b01; c.alu_op = 3'b001; c.ir_load = 1'b1; c.pc_write = 1'b1;
      end
      S_DECODE: begin
        c.ab_load = 1'b1; c.aluout_load = 1'b1; c.alusrcb = 2'b11; c.alu_op = 3'b001;
      end
      S_EXEC_R: begin
        c.alusrca = 1'b1; c.aluout_load = 1'b1;
        case (fn)
          FN_SUB:  c.alu_op = 3'b010;
          FN_AND:  c.alu_op = 3'b011;
          FN_SLT:  c.alu_op = 3'b111;
          default: c.alu_op = 3'b001;
        endcase
      end
      S_WB_R: begin
        c.reg_write = 1'b1; c.reg_dst = 2'b01;
        if (fn == FN_SLL || fn == FN_SRL || fn == FN_SRA) c.mem_to_reg = 3'b010;
        else if (fn == FN_SLT) begin
          // slt writes the compare result straight off the ALU, so keep it comparing
          c.mem_to_reg = 3'b011; c.alusrca = 1'b1; c.alu_op = 3'b111;
        end
      end
      S_JR:      begin c.alusrca = 1'b1; c.pc_write = 1'b1; end
      S_SH_LOAD: c.shift_reg = 3'b001;
      S_SH_OP: begin
        case (fn)
          FN_SRL:  c.shift_reg = 3'b011;
          FN_SRA:  c.shift_reg = 3'b100;
          default: c.shift_reg = 3'b010;
        endcase
      end
      S_EXEC_I, S_MEM_ADDR: begin
        c.alusrca = 1'b1; c.alusrcb = 2'b10; c.alu_op = 3'b001; c.aluout_load = 1'b1;
      end
      S_WB_I:              c.reg_write = 1'b1;
      S_MEM_RD, S_LW_WAIT: c.iord = 3'b001;
      S_WB_LW:  begin c.iord = 3'b001; c.reg_write = 1'b1; c.mem_to_reg = 3'b001; end
      S_MEM_WR: begin c.iord = 3'b001; c.mem_wr = 1'b1; end
      // pc_write in BRANCH is qualified by alu_zero outside the register
      S_BRANCH: begin c.alusrca = 1'b1; c.alu_op = 3'b010; c.pc_source = 3'b001; end
      S_JUMP:   begin c.pc_write = 1'b1; c.pc_source = 3'b010; end
      S_JAL: begin
        c.pc_write = 1'b1; c.pc_source = 3'b010;
        c.reg_write = 1'b1; c.reg_dst = 2'b10; c.mem_to_reg = 3'b100;
      end
      S_EXC_OPC, S_EXC_OVF: begin
        c.epc_load = 1'b1; c.alusrcb = 2'b01; c.alu_op = 3'b010;
        c.iord = (s == S_EXC_OPC) ? 3'b010 : 3'b011;
      end
      S_EXC_ADDR, S_EXC_WAIT, S_EXC_DATA: c.iord = iord_hold;
      S_EXC_PC: begin c.iord = iord_hold; c.pc_write = 1'b1; c.pc_source = 3'b100; end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign wait_done = (wait_cnt == WAIT_N);

  // Next-state decode
  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_RESET:      nxt = S_FETCH;
      S_FETCH:      nxt = (MEM_WAIT == 0) ? S_FETCH_END : S_FETCH_WAIT;
      S_FETCH_WAIT: nxt = wait_done ? S_FETCH_END : S_FETCH_WAIT;
      S_FETCH_END:  nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            case (funct)
              FN_ADD, FN_SUB, FN_AND, FN_SLT: nxt = S_EXEC_R;
              FN_JR:                          nxt = S_JR;
              FN_SLL, FN_SRL, FN_SRA:         nxt = S_SH_LOAD;
              default:                        nxt = EXC_EN ? S_EXC_OPC : S_FETCH;
            endcase
          end
          OP_ADDI:       nxt = S_EXEC_I;
          OP_LW, OP_SW:  nxt = S_MEM_ADDR;
          OP_BEQ, OP_BNE: nxt = S_BRANCH;
          OP_J:          nxt = S_JUMP;
          OP_JAL:        nxt = S_JAL;
          default:       nxt = EXC_EN ? S_EXC_OPC : S_FETCH;
        endcase
      end
      S_EXEC_R:   nxt = (EXC_EN && overflow && (funct == FN_ADD || funct == FN_SUB)) ? S_EXC_OVF : S_WB_R;
      S_EXEC_I:   nxt = (EXC_EN && overflow) ? S_EXC_OVF : S_WB_I;
      S_SH_LOAD:  nxt = S_SH_OP;
      S_SH_OP:    nxt = S_WB_R;
      S_MEM_ADDR: nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   nxt = (MEM_WAIT == 0) ? S_WB_LW : S_LW_WAIT;
      S_LW_WAIT:  nxt = wait_done ? S_WB_LW : S_LW_WAIT;
      S_EXC_OPC, S_EXC_OVF: nxt = S_EXC_ADDR;
      S_EXC_ADDR: nxt = (MEM_WAIT == 0) ? S_EXC_DATA : S_EXC_WAIT;
      S_EXC_WAIT: nxt = wait_done ? S_EXC_DATA : S_EXC_WAIT;
      S_EXC_DATA: nxt = S_EXC_PC;
      default:    nxt = S_FETCH;
    endcase
  end

  // State, registered control word and memory wait counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_RESET;
      ctrl     <= '0;
      wait_cnt <= 2'd0;
    end else begin
      state    <= nxt;
      ctrl     <= ctrl_of(nxt, funct, ctrl.iord);
      wait_cnt <= is_wait(nxt) ? (is_wait(state) ? wait_cnt + 2'd1 : 2'd1) : 2'd0;
    end
  end

  // alu_zero only exists during the BRANCH cycle, so the branch decision gates the PC load here
  assign branch_taken = (state == S_BRANCH) && ((opcode == OP_BNE) ? !alu_zero : alu_zero);

  assign pc_write       = ctrl.pc_write | branch_taken;
  assign mem_wr         = ctrl.mem_wr;
  assign ir_load        = ctrl.ir_load;
  assign ab_load        = ctrl.ab_load;
  assign aluout_load    = ctrl.aluout_load;
  assign epc_load       = ctrl.epc_load;
  assign reg_write      = ctrl.reg_write;
  assign sel_alusrca    = ctrl.alusrca;
  assign sel_alusrcb    = ctrl.alusrcb;
  assign alu_op         = ctrl.alu_op;
  assign sel_mux_iord   = ctrl.iord;
  assign sel_pc_source  = ctrl.pc_source;
  assign sel_reg_dst    = ctrl.reg_dst;
  assign sel_mem_to_reg = ctrl.mem_to_reg;
  assign sel_shift_src  = ctrl.shift_src;
  assign sel_shift_amt  = ctrl.shift_amt;
  assign sel_shift_reg  = ctrl.shift_reg;
  assign dbg_state      = state;

endmodule
